// File: rtl/burst_packer_r8.sv
// Packs words from a multi-read FIFO into bursts of up to 8 words with a one-cycle load latency.
// Optional: define BURST_PACKER_FLUSH_EN to flush a partial burst after TIMEOUT idle cycles.
module burst_packer_r8 #(
   parameter int WIDTH   = 32,
   parameter int BURST   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               softreset,
   input  logic [15:0]        count,
   input  logic [WIDTH*8-1:0] fifo_dout,
   output logic [3:0]         reads,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH*8-1:0] out_data,
   output logic [3:0]         out_len,
   output logic [15:0]        bursts
);

   localparam logic [0:0]  STATE_EMPTY = 1'b0;
   localparam logic [0:0]  STATE_HOLD  = 1'b1;
   localparam logic [15:0] BURST_W     = 16'(BURST);
   localparam logic [3:0]  BURST_R     = 4'(BURST);

   if (BURST < 1 || BURST > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("burst_packer_r8: BURST must be 1..8 and TIMEOUT 1..255");
   end

   logic [0:0]         state_r;
   logic [WIDTH*8-1:0] data_r;
   logic [3:0]         len_r;
   logic [15:0]        bursts_r;
   logic               load_ok_s;
   logic               full_s;
   logic               flush_s;
   logic               load_s;
   logic [3:0]         reads_s;
   logic [WIDTH*8-1:0] load_data_s;

   assign load_ok_s = (state_r == STATE_EMPTY) || out_ready;
   assign full_s    = load_ok_s && (count >= BURST_W);

`ifdef BURST_PACKER_FLUSH_EN
   localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
   logic       partial_s;
   logic [7:0] timer_r;

   assign partial_s = (count != 16'd0) && (count < BURST_W);
   assign flush_s   = load_ok_s && partial_s && (timer_r == TIMEOUT_W);

   // Idle timer: runs only while a partial burst waits; a stalled HOLD keeps it saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_r <= 8'd0;
      end else if (softreset || load_s || !partial_s) begin
         timer_r <= 8'd0;
      end else if (timer_r != TIMEOUT_W) begin
         timer_r <= timer_r + 8'd1;
      end else begin
         timer_r <= timer_r;
      end
   end
`else
   assign flush_s = 1'b0;
`endif

   // Pop request toward the FIFO; suppressed during either reset.
   always_comb begin
      reads_s = 4'd0;
      if (!rst_n || softreset) begin
         reads_s = 4'd0;
      end else if (full_s) begin
         reads_s = BURST_R;
      end else if (flush_s) begin
         reads_s = count[3:0];
      end else begin
         reads_s = 4'd0;
      end
   end

   assign load_s = (reads_s != 4'd0);

   // Burst image: words beyond the popped count are forced to zero.
   always_comb begin
      load_data_s = {(WIDTH*8){1'b0}};
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < reads_s) begin
            load_data_s[WIDTH*k +: WIDTH] = fifo_dout[WIDTH*k +: WIDTH];
         end else begin
            load_data_s[WIDTH*k +: WIDTH] = {WIDTH{1'b0}};
         end
      end
   end

   // Burst register, hand-off state and accepted-burst counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= STATE_EMPTY;
         data_r   <= {(WIDTH*8){1'b0}};
         len_r    <= 4'd0;
         bursts_r <= 16'd0;
      end else if (softreset) begin
         state_r  <= STATE_EMPTY;
         data_r   <= {(WIDTH*8){1'b0}};
         len_r    <= 4'd0;
         bursts_r <= 16'd0;
      end else begin
         if ((state_r == STATE_HOLD) && out_ready) begin
            bursts_r <= bursts_r + 16'd1;
         end else begin
            bursts_r <= bursts_r;
         end
         if (load_s) begin
            state_r <= STATE_HOLD;
            data_r  <= load_data_s;
            len_r   <= reads_s;
         end else if (out_ready) begin
            state_r <= STATE_EMPTY;
            data_r  <= data_r;
            len_r   <= len_r;
         end else begin
            state_r <= state_r;
            data_r  <= data_r;
            len_r   <= len_r;
         end
      end
   end

   assign reads     = reads_s;
   assign out_valid = (state_r == STATE_HOLD);
   assign out_data  = data_r;
   assign out_len   = len_r;
   assign bursts    = bursts_r;

endmodule

// File: tb/tb_burst_packer_r8.sv
// Scoreboard bench for burst_packer_r8: a queue-based FIFO/burst model predicts pops and bursts.
module tb_burst_packer_r8;

   localparam int WIDTH   = 32;
   localparam int BURST   = 8;
   localparam int TIMEOUT = 16;
`ifdef BURST_PACKER_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               softreset;
   logic [15:0]        count;
   logic [WIDTH*8-1:0] fifo_dout;
   logic [3:0]         reads;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH*8-1:0] out_data;
   logic [3:0]         out_len;
   logic [15:0]        bursts;

   always #5 clk = ~clk;

   burst_packer_r8 #(.WIDTH(WIDTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .softreset(softreset), .count(count),
      .fifo_dout(fifo_dout), .reads(reads), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_len(out_len), .bursts(bursts)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0]   fifo_q[$];
   logic [WIDTH*8-1:0] exp_data_q[$];
   logic [3:0]         exp_len_q[$];
   bit                 m_valid  = 1'b0;
   int                 m_idle   = 0;
   int unsigned        m_bursts = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_idle   = 0;
      m_bursts = 0;
      exp_data_q.delete();
      exp_len_q.delete();
   endtask

   // One clock cycle: drive at the falling edge, predict and check before the rising edge.
   task automatic step(input int push_n, input bit rdy, input bit srst);
      int                 exp_reads;
      int                 n;
      logic [WIDTH*8-1:0] d;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < push_n; i++) fifo_q.push_back(WIDTH'($urandom));
      n     = fifo_q.size();
      count = 16'(n);
      for (int k = 0; k < 8; k++)
         fifo_dout[WIDTH*k +: WIDTH] = (k < n) ? fifo_q[k] : WIDTH'($urandom);
      out_ready = rdy;
      softreset = srst;
      #2;
      if (srst || (m_valid && !rdy))                        exp_reads = 0;
      else if (n >= BURST)                                  exp_reads = BURST;
      else if (FLUSH_EN && n > 0 && m_idle >= TIMEOUT)      exp_reads = n;
      else                                                  exp_reads = 0;
      check("reads", 256'(reads), 256'(exp_reads));
      check("out_valid", 256'(out_valid), 256'(m_valid));
      check("bursts", 256'(bursts), 256'(m_bursts));
      if (srst) begin
         model_reset();
      end else begin
         if (m_valid && rdy) m_bursts = (m_bursts + 1) % 65536;
         if (exp_reads > 0) begin
            d = '0;
            for (int k = 0; k < exp_reads; k++) d[WIDTH*k +: WIDTH] = fifo_q.pop_front();
            exp_data_q.push_back(d);
            exp_len_q.push_back(4'(exp_reads));
            m_valid = 1'b1;
            m_idle  = 0;
         end else begin
            if (rdy) m_valid = 1'b0;
            if (n == 0 || n >= BURST) m_idle = 0;
            else if (m_idle < TIMEOUT) m_idle++;
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
      check({tag, "_out_len"}, 256'(out_len), 256'(0));
      check({tag, "_out_data"}, 256'(out_data), 256'(0));
      check({tag, "_bursts"}, 256'(bursts), 256'(0));
   endtask

   // Asynchronous reset pulse mid-cycle; outputs must clear without waiting for an edge.
   task automatic pulse_rst();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_cleared("rst");
      check("rst_reads", 256'(reads), 256'(0));
      model_reset();
   endtask

   // Monitor: compares the presented burst with the oldest expectation, retiring it on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_data_q.size() == 0) begin
               check("burst_expected", 256'(out_valid), 256'(0));
            end else begin
               check("out_data", 256'(out_data), 256'(exp_data_q[0]));
               check("out_len", 256'(out_len), 256'(exp_len_q[0]));
               if (out_ready === 1'b1 && softreset === 1'b0) begin
                  void'(exp_data_q.pop_front());
                  void'(exp_len_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [WIDTH*8-1:0] ramp;
      int                 push_n;
      rst_n     = 1'b0;
      softreset = 1'b0;
      count     = 16'd0;
      fifo_dout = '0;
      out_ready = 1'b0;
      #1;
      check_cleared("init");
      check("init_reads", 256'(reads), 256'(0));

      // Eight words 1..8 become one full burst.
      for (int k = 1; k <= 8; k++) fifo_q.push_back(WIDTH'(k));
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) ramp[WIDTH*k +: WIDTH] = WIDTH'(k + 1);
      check("ramp_data", 256'(out_data), 256'(ramp));
      check("ramp_len", 256'(out_len), 256'(8));

      // Twenty words, always ready: two back-to-back bursts then a residue of four.
      step(20, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0);

      // Partial residue sits idle: flushed only when the flush option is built in.
      for (int i = 0; i < 30; i++) step(0, 1'b1, 1'b0);

      // Backpressure: held burst must stay stable while more words wait.
      step(16, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) step(0, 1'b1, 1'b0);

      // Held burst plus a partial that has idled ten cycles, then asynchronous reset.
      fifo_q.delete();
      step(8, 1'b0, 1'b0);
      step(3, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(0, 1'b0, 1'b0);
      pulse_rst();
      for (int i = 0; i < 25; i++) step(0, 1'b1, 1'b0);

      // Same setup cleared by the synchronous soft reset instead.
      fifo_q.delete();
      step(8, 1'b0, 1'b0);
      step(3, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check_cleared("srst");
      for (int i = 0; i < 25; i++) step(0, 1'b1, 1'b0);

      // Randomised traffic with varying arrival rate, backpressure and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (fifo_q.size() > 40)      push_n = 0;
         else if ((i / 200) % 2 == 0) push_n = int'($urandom_range(0, 3));
         else                         push_n = ($urandom_range(0, 9) < 2) ? 1 : 0;
         if ($urandom_range(0, 999) == 0) pulse_rst();
         step(push_n, $urandom_range(0, 3) != 0, $urandom_range(0, 127) == 0);
      end
      step(0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
